// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage.
// Arbitration is either round-robin from a rotating pointer or fixed lowest-index priority.
module stream_mux_rr #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;
  logic                  out_valid_q, out_valid_d;

  logic                  gnt_vld;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  can_load, xfer;
  int                    scan_idx;

  // Scan order starts at ptr in round-robin mode and at 0 in fixed mode;
  // the first valid channel encountered wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = mode ? i : (int'(ptr_q) + i) % NUM_CH;
      if (!gnt_vld && in_valid[SEL_W'(scan_idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(scan_idx);
      end
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign xfer     = gnt_vld && can_load && !reset;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = ch_data[gnt_idx];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (!mode) ptr_d = SEL_W'((int'(gnt_idx) + 1) % NUM_CH);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
